// File: rtl/uart_rx_word_packer_if.sv
// rtl/uart_rx_word_packer_if.sv - byte-in / word-out signal bundle for uart_rx_word_packer
interface uart_rx_word_packer_if #(
  parameter int DERINLIK = 8
);
  logic [7:0]                    al_veri;
  logic                          al_gecerli;
  logic                          temizle;
  logic [31:0]                   kelime;
  logic                          kelime_gecerli;
  logic                          kelime_hazir;
  logic                          tasma;
  logic [$clog2(DERINLIK):0]     doluluk;

  // Producer/consumer side: drives bytes, flush and ready, observes words and status
  modport master (
    output al_veri, al_gecerli, temizle, kelime_hazir,
    input  kelime, kelime_gecerli, tasma, doluluk
  );

  // Packer side
  modport slave (
    input  al_veri, al_gecerli, temizle, kelime_hazir,
    output kelime, kelime_gecerli, tasma, doluluk
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// rtl/uart_rx_word_packer.sv - UART byte FIFO packing little-endian 32-bit words
module uart_rx_word_packer #(
  parameter int DERINLIK = 8
) (
  input logic                   clk_g,
  input logic                   rst_g,
  uart_rx_word_packer_if.slave  bus
);
  localparam int AW = $clog2(DERINLIK);
  localparam logic [AW:0] DOLU = (AW+1)'(DERINLIK);

  typedef enum logic {TOPLA = 1'b0, SUN = 1'b1} durum_t;

  durum_t          durum, durum_d;
  logic [1:0]      ek, ek_d;
  logic [AW-1:0]   yaz_ptr, oku_ptr;
  logic [AW:0]     sayac;
  logic [7:0]      mem [DERINLIK];
  logic [31:0]     kelime_r;
  logic            tasma_r;
  logic            pop, push, kayip;

  // Pop only depends on flops; the byte input reaches the write enable only
  assign pop   = (durum == TOPLA) && (sayac != '0) && !bus.temizle;
  assign push  = bus.al_gecerli && !bus.temizle && ((sayac != DOLU) || pop);
  assign kayip = bus.al_gecerli && !bus.temizle && (sayac == DOLU) && !pop;

  // FIFO pointers and occupancy; flush returns them to empty
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else if (bus.temizle) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else begin
      if (push) yaz_ptr <= yaz_ptr + AW'(1);
      if (pop)  oku_ptr <= oku_ptr + AW'(1);
      if (push && !pop)      sayac <= sayac + (AW+1)'(1);
      else if (pop && !push) sayac <= sayac - (AW+1)'(1);
    end
  end

  // Byte storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk_g) begin
    if (push) mem[yaz_ptr] <= bus.al_veri;
  end

  // Packer state register
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      durum <= TOPLA;
      ek    <= 2'd0;
    end else begin
      durum <= durum_d;
      ek    <= ek_d;
    end
  end

  // Packer next state: collect four bytes, then hold the word until accepted
  always_comb begin
    durum_d = durum;
    ek_d    = ek;
    if (bus.temizle) begin
      durum_d = TOPLA;
      ek_d    = 2'd0;
    end else begin
      case (durum)
        TOPLA: begin
          if (pop) begin
            if (ek == 2'd3) begin
              durum_d = SUN;
              ek_d    = 2'd0;
            end else begin
              ek_d = ek + 2'd1;
            end
          end
        end
        SUN: begin
          if (bus.kelime_hazir) durum_d = TOPLA;
        end
        default: durum_d = TOPLA;
      endcase
    end
  end

  // Word register filled lane by lane; flush leaves the data in place
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      kelime_r <= '0;
    end else if (pop) begin
      kelime_r[8*ek +: 8] <= mem[oku_ptr];
    end
  end

  // Sticky overflow flag, cleared only by flush or reset
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      tasma_r <= 1'b0;
    end else if (bus.temizle) begin
      tasma_r <= 1'b0;
    end else if (kayip) begin
      tasma_r <= 1'b1;
    end
  end

  assign bus.kelime         = kelime_r;
  assign bus.kelime_gecerli = (durum == SUN);
  assign bus.tasma          = tasma_r;
  assign bus.doluluk        = sayac;
endmodule

// File: doc/uart_rx_word_packer.md
# uart_rx_word_packer

Receive-side stage that sits directly downstream of the UART receiver. It takes the receiver's one-cycle byte-valid pulses into a small byte FIFO and packs consecutive bytes, little-endian, into 32-bit words. Words go to the consumer, such as the program loader or a register bus bridge, over a valid/ready handshake. The FIFO absorbs consumer stalls, and any byte lost to overflow is flagged.

## Interface
- `DERINLIK`, default 8: byte FIFO depth; must be a power of two, ≥ 2.
- `clk_g`, in, 1: the single clock.
- `rst_g`, in, 1: reset, asynchronous and active-high.
- `al_veri`, in, 8: received byte from the UART receiver.
- `al_gecerli`, in, 1: one-cycle pulse; `al_veri` is valid this cycle.
- `temizle`, in, 1: synchronous flush (resynchronise word boundary).
- `kelime`, out, 32: assembled word; byte k is at bits [8k+7:8k].
- `kelime_gecerli`, out, 1: `kelime` is valid.
- `kelime_hazir`, in, 1: consumer accepts `kelime`.
- `tasma`, out, 1: sticky overflow flag.
- `doluluk`, out, log2(DERINLIK)+1: current FIFO occupancy in bytes.

## Operation
- **Byte FIFO**
  - Circular buffer with write/read pointers of log2(DERINLIK) bits, wrapping modulo DERINLIK. Occupancy counter 0..DERINLIK is driven to `doluluk`.
  - Write happens on `al_gecerli` when occupancy < DERINLIK, or when a pop occurs in the same cycle (simultaneous push/pop at full is legal; occupancy stays DERINLIK).
  - When `al_gecerli` arrives while full and there is no pop that cycle: the byte is dropped, `tasma` is set, and occupancy is unchanged.
  - Simultaneous push and pop with occupancy ≥ 1: occupancy unchanged.
- **Packer FSM**, two states:
  - `TOPLA`: a 2-bit byte index `ek` (0..3). When the FIFO is non-empty, pop one byte per cycle into `kelime[8*ek+7:8*ek]`. On `ek`=3, go to `SUN` and set `ek` to 0; otherwise `ek` increments.
  - `SUN`: `kelime_gecerli`=1; no pops. When `kelime_hazir`=1, the transfer completes: go to `TOPLA`, `kelime_gecerli`=0.
- **`kelime` handling**
  - `kelime` is registered and stable throughout `SUN`. After a transfer it holds its value until overwritten byte by byte.
  - Bytes of a partially assembled word are never presented.
- **`temizle`** has priority over every other action in its cycle:
  - FIFO pointers and occupancy go to 0, `ek` goes to 0, FSM goes to `TOPLA`, `kelime_gecerli` goes to 0, and `tasma` goes to 0.
  - An `al_gecerli` in the same cycle is discarded.
  - `kelime` data is not cleared.
- **`tasma`** is cleared only by `temizle` or `rst_g`.

## Timing
- **Reset values**: `kelime`=0, `kelime_gecerli`=0, `tasma`=0, `doluluk`=0, FSM=`TOPLA`, `ek`=0, pointers 0.
- **Reset behaviour**: `rst_g` takes effect immediately (asynchronous) and may arrive mid-word or mid-handshake; partial words are discarded. Deassertion is assumed synchronous to `clk_g` upstream.
- **Push**: `al_gecerli` sampled at edge E; `doluluk` reflects the push after E.
- **Pop**: the packer sees the non-empty FIFO after E and pops at edge E+1. Byte-in to packer register latency is 2 edges.
- **Word valid**: `kelime_gecerli` rises after the edge that pops byte 3, i.e. after edge E+1 relative to byte 3's `al_gecerli` when the FIFO was empty.
- **Handshake**:
  - The transfer is the edge where `kelime_gecerli`=1 and `kelime_hazir`=1.
  - The next pop occurs no earlier than the following edge, so there is at most one word per 5 cycles.
  - `kelime_hazir` may be high before valid; `kelime_gecerli` never drops without a transfer, except on `temizle`/`rst_g`.
- **Path**: `al_gecerli` → write-enable is the only combinational path through the block; all outputs come directly from flops.
- **Capacity**: with the consumer stalled, total buffering is DERINLIK bytes + one held word (4 bytes).

## Test plan
- **Basic pack**: `kelime_hazir`=1; pulse bytes 0x11, 0x22, 0x33, 0x44, 20 cycles apart → one word `kelime`=0x44332211; `kelime_gecerli` high exactly 1 cycle; `tasma`=0; `doluluk` returns to 0.
- **Stall and overflow** (DERINLIK=8): `kelime_hazir`=0; pulse bytes 0x01..0x0D.
  - After byte 12, `doluluk`=8.
  - Byte 0x0D is dropped and `tasma`=1.
  - Release `kelime_hazir` → words 0x04030201, 0x08070605, 0x0C0B0A09 in order, then no further word; `tasma` stays 1.
- **Full push/pop**: FIFO at 8 with the packer popping; `al_gecerli` in the same cycle as the pop → byte accepted, `doluluk` stays 8, `tasma`=0.
- **Flush resync**: send 0x55, 0x66, assert `temizle` for 1 cycle, then send 0xA0..0xA3 → single word 0xA3A2A1A0; `tasma`=0.
- **Async reset mid-handshake**: word pending (`kelime_gecerli`=1), assert `rst_g` between clock edges → all outputs go immediately to reset values; a subsequent 4-byte sequence packs correctly from index 0.
- **Pointer wrap**: stream 40 bytes 0x00..0x27 with random `kelime_hazir` backpressure (no overflow) → 10 words, each 0x(4k+3)(4k+2)(4k+1)(4k), in order.
